spdif_tx_rate_switch: RTL and testbench
=======================================

Name: spdif_tx_rate_switch

Overview:
- Sequencer that drives the SPDIF TX clock-mux select into the clock/reset block.
- Requested rates are debounced before any switch happens.
- Around each switch it mutes the transmitter, holds it in reset, changes the select, waits for the mux output to settle, then releases the transmitter.
- Runs on the system clock and sits between the SPDIF RX rate detector and the clock/reset block's TX select input, with a tight loop to the SPDIF TX core.

Parameters:
- DEBOUNCE_CYCLES, 1024: consecutive stable-request cycles needed before a switch starts (>=2).
- MUTE_TIMEOUT, 4096: maximum cycles to wait for TX frame-boundary idle after muting (>=2).
- SETTLE_CYCLES, 256: cycles TX is held in reset after the select changes (>=2).
- INIT_SEL, 1'b1: select value at reset (1=48 kHz, 0=44.1 kHz).
- CNT_W, 13: width of the shared counter; must satisfy 2^CNT_W > max(DEBOUNCE_CYCLES, MUTE_TIMEOUT, SETTLE_CYCLES).

Ports:
- i_sys_clk  in  1  system clock, 36.864 MHz.
- i_sys_rst_n  in  1  reset; synchronous, active-low.
- i_rate_req  in  1  requested TX rate (1=48 kHz, 0=44.1 kHz); qualified by i_rate_valid.
- i_rate_valid  in  1  RX detector has a locked rate estimate.
- i_tx_idle  in  1  TX core is at a frame boundary (already synchronised to i_sys_clk).
- o_spdif_tx_clk_sel  out  1  select to the TX clock BUFGMUX; registered.
- o_tx_mute  out  1  forces TX to output zero samples.
- o_tx_rst  out  1  active-high reset to the TX core.
- o_busy  out  1  high in every state except IDLE.
- o_switch_done  out  1  one-cycle pulse on each SETTLE->IDLE exit.
- o_mute_timeout  out  1  one-cycle pulse when MUTE exits on timeout rather than on i_tx_idle.

Behaviour:
- Clocking and reset:
  - Single clock; all outputs registered.
  - Reset is sampled only on rising i_sys_clk while i_sys_rst_n=0.
- Reset values:
  - state=SETTLE, cnt=0, cand=INIT_SEL.
  - o_spdif_tx_clk_sel=INIT_SEL, o_tx_mute=1, o_tx_rst=1, o_busy=1.
  - o_switch_done=0, o_mute_timeout=0.
- Shared counter cnt:
  - Cleared on every state entry.
  - Increments by 1 per cycle inside a state; never wraps, because each state exits at its terminal count.
- States:
  - IDLE: mute=0, rst=0, busy=0.
    - If i_rate_valid=1 and i_rate_req != o_spdif_tx_clk_sel: latch cand<=i_rate_req and go to DEBOUNCE.
    - Otherwise stay.
  - DEBOUNCE: outputs as IDLE except busy=1.
    - If i_rate_valid=0 or i_rate_req != cand: go to IDLE; no output changes.
    - Else if cnt==DEBOUNCE_CYCLES-1: go to MUTE.
    - The request must be stable for DEBOUNCE_CYCLES+1 consecutive cycles, counting the IDLE detect cycle.
  - MUTE: mute=1.
    - If i_tx_idle=1: go to SWITCH. i_tx_idle is ignored during the entry cycle (cnt==0).
    - Else if cnt==MUTE_TIMEOUT-1: go to SWITCH and pulse o_mute_timeout.
    - If both conditions are true in the same cycle, the i_tx_idle exit takes precedence and there is no timeout pulse.
  - SWITCH: exactly 1 cycle.
    - rst=1, mute=1.
    - o_spdif_tx_clk_sel<=cand, visible from the following cycle.
    - Next state is SETTLE.
  - SETTLE: rst=1, mute=1.
    - At cnt==SETTLE_CYCLES-1: go to IDLE.
    - In the first IDLE cycle: o_switch_done=1, rst=0, mute=0.
- Request handling:
  - Requests are ignored from MUTE through SETTLE.
  - On return to IDLE the request is re-evaluated; a request that changed during the sequence starts a new sequence.
  - A request equal to the current select never leaves IDLE.
- After reset:
  - TX is held in reset for SETTLE_CYCLES cycles after i_sys_rst_n rises.
  - o_switch_done then pulses once, then the block sits in IDLE.
- Reset mid-sequence: from any state, go to the reset values within one clock.
  - o_spdif_tx_clk_sel returns to INIT_SEL.
  - Mute and rst are asserted immediately.
- Glitch-free requirement: o_spdif_tx_clk_sel changes only in the cycle after SWITCH. At that point o_tx_rst=1 and o_tx_mute=1, and have both been high since at least the SWITCH cycle.
- Invariant: o_tx_rst=1 implies o_tx_mute=1.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=8, MUTE_TIMEOUT=16, SETTLE_CYCLES=4, INIT_SEL=1.
1. Release reset, hold i_rate_valid=0 -> o_tx_rst=1 for 4 cycles, then done pulse with o_tx_rst=0, sel=1, busy=0.
2. valid=1, req=0, i_tx_idle=1 -> busy rises the cycle after detect. MUTE is entered after 9 stable cycles, SWITCH 2 cycles later, sel=0 the cycle after SWITCH, done 4 cycles later. Total: 1 (detect) + 8 + 2 + 1 + 4 = 16 cycles from detect to done. No timeout pulse.
3. Toggle req 0/1 every 5 cycles with valid=1 -> never leaves DEBOUNCE/IDLE; sel stays 1 and mute never rises.
4. Request 0 with i_tx_idle held 0 -> mute for 16 cycles, o_mute_timeout pulses once, then switch completes with sel=0.
5. Pull i_sys_rst_n low during SETTLE of a 1->0 switch -> next cycle sel=1, mute=1, rst=1. After release, the post-reset sequence from scenario 1 repeats.
6. Change req back to 1 during MUTE of a 1->0 switch -> the switch completes with sel=0, then a second sequence runs and restores sel=1. Exactly two done pulses in total.

Source files
------------

// File: rtl/spdif_tx_rate_switch.sv
// Sequences a glitch-free change of the SPDIF TX clock-mux select: debounce the
// requested rate, mute TX, hold it in reset across the select change, let the mux settle.
module spdif_tx_rate_switch #(
  parameter int   DEBOUNCE_CYCLES = 1024,
  parameter int   MUTE_TIMEOUT    = 4096,
  parameter int   SETTLE_CYCLES   = 256,
  parameter logic INIT_SEL        = 1'b1,
  parameter int   CNT_W           = 13
) (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst_n,
  input  logic       i_rate_req,
  input  logic       i_rate_valid,
  input  logic       i_tx_idle,
  output logic       o_spdif_tx_clk_sel,
  output logic       o_tx_mute,
  output logic       o_tx_rst,
  output logic       o_busy,
  output logic       o_switch_done,
  output logic       o_mute_timeout,
  output logic [2:0] o_dbg_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEBOUNCE = 3'd1,
    MUTE     = 3'd2,
    SWITCH   = 3'd3,
    SETTLE   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MUTE_LAST   = CNT_W'(MUTE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             cand, cand_d;
  logic             sel_d, mute_d, rst_d, busy_d, done_d, timeout_d;
  logic             mute_timeout_hit;

  // i_rate_valid is a level qualifier, not a handshake: i_rate_req is only
  // meaningful while it is high, and no acknowledge is ever returned.

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) begin
      state              <= SETTLE;
      cnt                <= '0;
      cand               <= INIT_SEL;
      o_spdif_tx_clk_sel <= INIT_SEL;
      o_tx_mute          <= 1'b1;
      o_tx_rst           <= 1'b1;
      o_busy             <= 1'b1;
      o_switch_done      <= 1'b0;
      o_mute_timeout     <= 1'b0;
    end else begin
      state              <= state_next;
      cnt                <= cnt_d;
      cand               <= cand_d;
      o_spdif_tx_clk_sel <= sel_d;
      o_tx_mute          <= mute_d;
      o_tx_rst           <= rst_d;
      o_busy             <= busy_d;
      o_switch_done      <= done_d;
      o_mute_timeout     <= timeout_d;
    end
  end

  always_comb begin
    state_next       = state;
    mute_timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (i_rate_valid && (i_rate_req != o_spdif_tx_clk_sel)) state_next = DEBOUNCE;
      end
      DEBOUNCE: begin
        if (!i_rate_valid || (i_rate_req != cand)) state_next = IDLE;
        else if (cnt == DEB_LAST)                   state_next = MUTE;
      end
      MUTE: begin
        // The entry cycle ignores i_tx_idle so mute reaches TX before we trust it.
        if (i_tx_idle && (cnt != '0)) begin
          state_next = SWITCH;
        end else if (cnt == MUTE_LAST) begin
          state_next       = SWITCH;
          mute_timeout_hit = 1'b1;
        end
      end
      SWITCH: state_next = SETTLE;
      SETTLE: begin
        if (cnt == SETTLE_LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered versions of what the next state demands, so each
  // output lines up with the state it belongs to.
  always_comb begin
    mute_d    = (state_next == MUTE) || (state_next == SWITCH) || (state_next == SETTLE);
    rst_d     = (state_next == SWITCH) || (state_next == SETTLE);
    busy_d    = (state_next != IDLE);
    done_d    = (state == SETTLE) && (state_next == IDLE);
    timeout_d = mute_timeout_hit;
    sel_d     = (state == SWITCH) ? cand : o_spdif_tx_clk_sel;
    cand_d    = ((state == IDLE) && (state_next == DEBOUNCE)) ? i_rate_req : cand;
    if ((state_next != state) || (state == IDLE)) cnt_d = '0;
    else                                          cnt_d = cnt + CNT_W'(1);
  end

  assign o_dbg_state = state;

endmodule

// File: tb/tb_spdif_tx_rate_switch.sv
// Directed bench for spdif_tx_rate_switch with small parameters (8/16/4, INIT_SEL=1).
module tb_spdif_tx_rate_switch;

  logic       clk;
  logic       rst_n;
  logic       rate_req, rate_valid, tx_idle;
  logic       sel, mute, txrst, busy, done, tmo;
  logic [2:0] dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [0:0] exp_q[$];

  logic primed = 1'b0;
  logic prev_sel, prev_mute, prev_rst;
  logic mon_en = 1'b0;

  localparam logic [2:0] S_IDLE = 3'd0, S_DEB = 3'd1, S_MUTE = 3'd2, S_SETTLE = 3'd4;

  spdif_tx_rate_switch #(
    .DEBOUNCE_CYCLES(8),
    .MUTE_TIMEOUT   (16),
    .SETTLE_CYCLES  (4),
    .INIT_SEL       (1'b1),
    .CNT_W          (13)
  ) dut (
    .i_sys_clk         (clk),
    .i_sys_rst_n       (rst_n),
    .i_rate_req        (rate_req),
    .i_rate_valid      (rate_valid),
    .i_tx_idle         (tx_idle),
    .o_spdif_tx_clk_sel(sel),
    .o_tx_mute         (mute),
    .o_tx_rst          (txrst),
    .o_busy            (busy),
    .o_switch_done     (done),
    .o_mute_timeout    (tmo),
    .o_dbg_state       (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard / invariant monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (!primed) begin
        primed = 1'b1;
      end else begin
        chk("inv_rst_implies_mute", {31'd0, (!txrst || mute)}, 32'd1);
        if (done) begin
          if (exp_q.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
          else                   chk("done_sel", {31'd0, sel}, {31'd0, exp_q.pop_front()});
        end
        if (sel !== prev_sel)
          chk("sel_change_guarded", {31'd0, (txrst && mute && prev_rst && prev_mute)}, 32'd1);
      end
      prev_sel  = sel;
      prev_mute = mute;
      prev_rst  = txrst;
    end
  end

  // Called in the first cycle after the last reset edge (SETTLE, cnt=0).
  task automatic post_reset(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_rst_hold"}, {31'd0, txrst}, 32'd1);
      chk({tag, "_no_done"}, {31'd0, done}, 32'd0);
      tick();
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_rst_rel"}, {31'd0, txrst}, 32'd0);
    chk({tag, "_mute_rel"}, {31'd0, mute}, 32'd0);
    chk({tag, "_sel"}, {31'd0, sel}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_state"}, {29'd0, dbg_state}, {29'd0, S_IDLE});
    tick();
    chk({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
  endtask

  // Ticks max_cyc cycles, recording the first cycle (1-based) at which each event shows.
  task automatic run_seq(input int max_cyc, output int t_busy, output int t_mute,
                         output int t_rst, output int t_sel, output int t_done,
                         output int n_done, output int n_to);
    logic sel0;
    sel0 = sel;
    t_busy = -1; t_mute = -1; t_rst = -1; t_sel = -1; t_done = -1; n_done = 0; n_to = 0;
    for (int k = 1; k <= max_cyc; k++) begin
      tick();
      if (busy && t_busy < 0)          t_busy = k;
      if (mute && t_mute < 0)          t_mute = k;
      if (txrst && t_rst < 0)          t_rst = k;
      if ((sel !== sel0) && t_sel < 0) t_sel = k;
      if (done) begin
        n_done++;
        if (t_done < 0) t_done = k;
      end
      if (tmo) n_to++;
    end
  endtask

  int tb_, tm, tr, ts, td, nd, nt;

  initial begin
    rst_n = 1'b0; rate_valid = 1'b0; rate_req = 1'b1; tx_idle = 1'b0;
    repeat (3) tick();

    // reset values
    chk("rst_sel", {31'd0, sel}, 32'd1);
    chk("rst_mute", {31'd0, mute}, 32'd1);
    chk("rst_txrst", {31'd0, txrst}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_tmo", {31'd0, tmo}, 32'd0);
    chk("rst_state", {29'd0, dbg_state}, {29'd0, S_SETTLE});
    mon_en = 1'b1;

    // 1: post-reset hold then done pulse
    exp_q.push_back(1'b1);
    rst_n = 1'b1;
    post_reset("s1");

    // 3: request toggling every 5 cycles never gets past DEBOUNCE
    rate_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c % 5 == 0) rate_req = ~rate_req;
      tick();
      chk("s3_mute", {31'd0, mute}, 32'd0);
      chk("s3_sel", {31'd0, sel}, 32'd1);
      chk("s3_state", {31'd0, (dbg_state == S_IDLE || dbg_state == S_DEB)}, 32'd1);
    end
    rate_valid = 1'b0; rate_req = 1'b1;
    tick(); tick();
    chk("s3_idle", {29'd0, dbg_state}, {29'd0, S_IDLE});

    // 2: clean 1->0 switch with TX already idle
    rate_valid = 1'b1; rate_req = 1'b0; tx_idle = 1'b1;
    chk("s2_busy_detect", {31'd0, busy}, 32'd0);
    exp_q.push_back(1'b0);
    run_seq(20, tb_, tm, tr, ts, td, nd, nt);
    chk("s2_t_busy", tb_, 1);
    chk("s2_t_mute", tm, 9);
    chk("s2_t_rst", tr, 11);
    chk("s2_t_sel", ts, 12);
    chk("s2_t_done", td, 16);
    chk("s2_n_done", nd, 1);
    chk("s2_n_tmo", nt, 0);
    chk("s2_sel", {31'd0, sel}, 32'd0);

    // equal request never leaves IDLE
    tick();
    chk("s2_eq_idle", {29'd0, dbg_state}, {29'd0, S_IDLE});

    // back to 48 kHz
    rate_req = 1'b1;
    exp_q.push_back(1'b1);
    run_seq(20, tb_, tm, tr, ts, td, nd, nt);
    chk("s2b_t_done", td, 16);
    chk("s2b_t_sel", ts, 12);
    chk("s2b_sel", {31'd0, sel}, 32'd1);

    // 4: TX never reports idle -> mute timeout
    rate_req = 1'b0; tx_idle = 1'b0;
    exp_q.push_back(1'b0);
    run_seq(36, tb_, tm, tr, ts, td, nd, nt);
    chk("s4_t_mute", tm, 9);
    chk("s4_t_rst", tr, 25);
    chk("s4_t_sel", ts, 26);
    chk("s4_t_done", td, 30);
    chk("s4_n_tmo", nt, 1);
    chk("s4_n_done", nd, 1);
    chk("s4_sel", {31'd0, sel}, 32'd0);

    rate_req = 1'b1; tx_idle = 1'b1;
    exp_q.push_back(1'b1);
    run_seq(20, tb_, tm, tr, ts, td, nd, nt);
    chk("s4b_t_done", td, 16);
    chk("s4b_sel", {31'd0, sel}, 32'd1);

    // 6: request flips back during MUTE -> two sequences
    rate_req = 1'b0; tx_idle = 1'b0;
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    repeat (10) tick();
    chk("s6_in_mute", {29'd0, dbg_state}, {29'd0, S_MUTE});
    rate_req = 1'b1; tx_idle = 1'b1;
    run_seq(30, tb_, tm, tr, ts, td, nd, nt);
    chk("s6_n_done", nd, 2);
    chk("s6_t_done", td, 6);
    chk("s6_n_tmo", nt, 0);
    chk("s6_sel", {31'd0, sel}, 32'd1);

    // 5: reset during SETTLE of a 1->0 switch
    rate_req = 1'b0; tx_idle = 1'b1;
    repeat (13) tick();
    chk("s5_in_settle", {29'd0, dbg_state}, {29'd0, S_SETTLE});
    chk("s5_sel_new", {31'd0, sel}, 32'd0);
    rst_n = 1'b0; rate_valid = 1'b0;
    tick();
    chk("s5_rst_sel", {31'd0, sel}, 32'd1);
    chk("s5_rst_mute", {31'd0, mute}, 32'd1);
    chk("s5_rst_txrst", {31'd0, txrst}, 32'd1);
    chk("s5_rst_busy", {31'd0, busy}, 32'd1);
    exp_q.push_back(1'b1);
    rst_n = 1'b1;
    post_reset("s5");

    repeat (3) tick();
    chk("exp_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
